// File: rtl/dt_pkg.sv
// Shared types and image geometry for the distance-transform result packer.
package dt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } pk_state_t;

  localparam int IMG_PIX      = 16384;
  localparam int IMG_WORDS    = 1024;
  localparam int PIX_PER_WORD = 16;

endpackage

// File: rtl/dt_bit_packer.sv
// Serial-in packer: gathers PIX_PER_WORD valid bits MSB-first into one word.
module dt_bit_packer
  import dt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        vld_in,
  input  logic        bit_in,
  output logic        grp_last,
  output logic        word_vld,
  output logic [15:0] word
);

  logic [3:0]  cnt_p1;
  logic [14:0] shift_p1;

  assign grp_last = vld_in && (cnt_p1 == 4'(PIX_PER_WORD - 1));

  // stage p1: group accumulation; word is emitted one cycle after its last bit
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p1   <= '0;
      shift_p1 <= '0;
      word_vld <= 1'b0;
      word     <= '0;
    end else begin
      word_vld <= grp_last;
      if (vld_in) begin
        cnt_p1   <= cnt_p1 + 4'd1;
        shift_p1 <= {shift_p1[13:0], bit_in};
      end
      if (grp_last)
        word <= {shift_p1, bit_in};
    end
  end

endmodule

// File: rtl/dt_res_packer.sv
// Scans the DT result memory, binarizes each byte and writes 16-pixel STI words.
// Optional running XOR checksum on pk_sum when DT_PACK_CHECKSUM_EN is defined.
module dt_res_packer
  import dt_pkg::*;
#(
  parameter logic [7:0] THRESH  = 8'd0,
  parameter int         PIX_AW  = 14,
  parameter int         WORD_AW = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               res_rd,
  output logic [PIX_AW-1:0]  res_addr,
  input  logic [7:0]         res_di,
  output logic               pk_wr,
  output logic [WORD_AW-1:0] pk_addr,
  output logic [15:0]        pk_do,
  output logic               busy,
  output logic               done,
  output logic [15:0]        pk_sum
);

  pk_state_t          state, state_nx;
  logic               go, rd_last, wr_last;
  logic               vld_p0, bit_p0;
  logic               grp_last;
  logic [WORD_AW-1:0] wr_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    rd_last  = 1'b0;
    wr_last  = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        go       = 1'b1;
        state_nx = RUN;
      end
      RUN: if (res_addr == {PIX_AW{1'b1}}) begin
        rd_last  = 1'b1;
        state_nx = FLUSH;
      end
      FLUSH: if (pk_wr && (pk_addr == {WORD_AW{1'b1}})) begin
        wr_last  = 1'b1;
        state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_rd   <= 1'b0;
      res_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_idx   <= '0;
      pk_addr  <= '0;
    end else begin
      if (go) begin
        res_rd   <= 1'b1;
        res_addr <= '0;
        busy     <= 1'b1;
        done     <= 1'b0;
        wr_idx   <= '0;
      end else begin
        if (state == RUN) begin
          if (rd_last) res_rd   <= 1'b0;
          else         res_addr <= res_addr + PIX_AW'(1);
        end
        if (wr_last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        if (grp_last) begin
          pk_addr <= wr_idx;
          wr_idx  <= wr_idx + WORD_AW'(1);
        end
      end
    end
  end

  // stage p0: capture the byte read this cycle and binarize it
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      bit_p0 <= 1'b0;
    end else begin
      vld_p0 <= res_rd;
      bit_p0 <= (res_di > THRESH);
    end
  end

  dt_bit_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .vld_in   (vld_p0),
    .bit_in   (bit_p0),
    .grp_last (grp_last),
    .word_vld (pk_wr),
    .word     (pk_do)
  );

`ifdef DT_PACK_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || go) pk_sum <= '0;
    else if (pk_wr)  pk_sum <= pk_sum ^ pk_do;
  end
`else
  assign pk_sum = 16'h0000;
`endif

endmodule

// File: doc/dt_res_packer.md
Name: dt_res_packer

Overview:
- Read-back encoder for the distance-transform result memory; the inverse of the DT input stage, which unpacks 16-pixel STI words into per-pixel bytes.
- Scans all 16384 result bytes with the res_RAM read protocol, binarizes each byte against a threshold, and packs 16 pixels MSB-first into one 16-bit word.
- Writes the 1024 packed words to an STI-format memory.
- Used to regenerate the binary object mask from DT results for self-checking and for the next pipeline stage.

Parameters:
- THRESH, 8'd0: a pixel bit is 1 when res_di > THRESH, compared as unsigned 8-bit.
- PIX_AW, 14: pixel address width; 16384 pixels.
- WORD_AW, 10: packed word address width; PIX_AW-4.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin scan; sampled only in IDLE or DONE.
- res_rd  out  1  result-memory read enable.
- res_addr  out  PIX_AW  result-memory pixel address.
- res_di  in  8  result byte. Memory captures it at the negedge after res_rd/res_addr are driven; valid at the following posedge.
- pk_wr  out  1  packed-word write strobe; memory writes on the posedge.
- pk_addr  out  WORD_AW  packed-word address.
- pk_do  out  16  packed word; bit 15 = lowest pixel of the group.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  level; high from scan completion until the next start or reset.
- pk_sum  out  16  checksum (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high) drives state to IDLE and clears all outputs to 0: res_rd, res_addr, pk_wr, pk_addr, pk_do, busy, done, pk_sum. It also clears the internal counters, the shift register and the valid pipe.
- All outputs are registered.
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE: start=1 -> RUN.
  - RUN: last address issued -> FLUSH.
  - FLUSH: last word written -> DONE.
  - DONE: start=1 -> RUN; done clears in the same cycle.
- RUN cycle numbering: cycle 0 is the first cycle after start is sampled.
  - In cycle k, res_rd=1 and res_addr=k, for k = 0..16383; one read per cycle, no bubbles.
  - Read latency is 1: the byte for address k is sampled at the posedge ending cycle k+1, tracked by a 1-bit valid pipe.
- Packing: bit = (res_di > THRESH). A 15-bit shift register accumulates the group, MSB-first.
- Word write: when pixel p with p[3:0]==15 is sampled, the next cycle has pk_wr=1, pk_addr=p[13:4], pk_do={shift[14:0],bit}. pk_wr is a 1-cycle pulse.
- Resulting write timing:
  - First write is in cycle 17 (word 0).
  - Writes then occur every 16 cycles.
  - Last write is in cycle 16385 (word 1023).
  - done=1 and busy=0 from cycle 16386.
- FLUSH: res_rd=0 and res_addr holds 16383. The pipe drains and no new reads are issued.
- pk_addr and pk_do hold their last values when pk_wr=0.
- Address counters wrap only at the terminal count. Exactly 1024 writes per scan, and never a partial word.
- start in RUN or FLUSH is ignored.
- Reset mid-scan aborts immediately: no further pk_wr, and the next start rescans from pixel 0.

Optional Feature:
- Macro: DT_PACK_CHECKSUM_EN.
- Defined: pk_sum = running XOR of every pk_do written. It clears on start and reset, updates in the cycle after each pk_wr, and is final when done rises.
- Undefined: pk_sum is tied to 16'h0000 and no checksum logic is synthesized.

Decomposition:
- Shared package dt_pkg holds:
  - state enum pk_state_t (IDLE, RUN, FLUSH, DONE);
  - constants IMG_PIX=16384, IMG_WORDS=1024, PIX_PER_WORD=16.
- One sub-module, dt_bit_packer: serial-in 16-bit packer with 4-bit group counter and valid-in/word-valid-out. The FSM and address generation stay in dt_res_packer.

Test Plan:
- All result bytes 0, THRESH=0: start -> 1024 writes of 16'h0000 at words 0..1023; first pk_wr in cycle 17, done rises in cycle 16386.
- All bytes 8'hFF: every pk_do = 16'hFFFF; res_rd high for exactly 16384 cycles.
- Only pixel 0 = 8'h01: word 0 = 16'h8000. Only pixel 16383 = 8'h05: word 1023 = 16'h0001. All other words 16'h0000.
- THRESH=3, pixels 0..3 = 3,4,0,200, rest 0: word 0 = 16'h5000.
- Reset asserted in RUN cycle 100: no pk_wr afterwards, done=0, busy=0. A new start completes a full, correct scan.
- DT_PACK_CHECKSUM_EN defined, words alternating 16'hAAAA/16'h5555 (1024 words): pk_sum = 16'h0000 at done. Macro undefined: pk_sum stays 0.
